// File: rtl/leve1_ma.sv
// LEVE1 RV64 memory-access / writeback stage.
// Non-memory instructions retire one cycle after acceptance. Loads and stores
// run a request/grant/response transaction on the data bus while EX is stalled.
module leve1_ma #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            EX_VALID,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [31:0]     EX_INSTR,
  input  logic            EX_WE,
  input  logic [XLEN-1:0] EX_RD,
  input  logic [XLEN-1:0] EX_CSRD,
  input  logic [XLEN-1:0] EX_RS2,
  output logic            MA_READY,
  output logic            DMEM_REQ,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic            DMEM_WE,
  output logic [7:0]      DMEM_WSTRB,
  output logic [63:0]     DMEM_WDATA,
  input  logic            DMEM_GNT,
  input  logic            DMEM_RVALID,
  input  logic [63:0]     DMEM_RDATA,
  output logic            WB_VALID,
  output logic [XLEN-1:0] WB_PC,
  output logic [31:0]     WB_INSTR,
  output logic            WB_RF_WE,
  output logic [4:0]      WB_RD_ADDR,
  output logic [XLEN-1:0] WB_RD,
  output logic            WB_CSR_WE,
  output logic [11:0]     WB_CSR_ADDR,
  output logic [XLEN-1:0] WB_CSRD,
  output logic            WB_EXC,
  output logic [3:0]      WB_EXC_CAUSE
);

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSTR_MRET = 32'h30200073;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Byte enables for an access of 2^size bytes starting at lane off.
  function automatic logic [7:0] store_strobe(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] mask;
    case (size)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << off;
  endfunction

  // Natural alignment check: halfword, word and doubleword need zero low bits.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  // Sign/zero extension of lane-shifted load data selected by funct3.
  function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] d);
    logic [63:0] res;
    case (f3)
      3'b000:  res = {{56{d[7]}},  d[7:0]};
      3'b001:  res = {{48{d[15]}}, d[15:0]};
      3'b010:  res = {{32{d[31]}}, d[31:0]};
      3'b100:  res = {56'd0, d[7:0]};
      3'b101:  res = {48'd0, d[15:0]};
      3'b110:  res = {32'd0, d[31:0]};
      default: res = d;
    endcase
    return res;
  endfunction

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_mem;
  logic       w_is_mret;
  logic       w_illegal;
  logic       w_misal;
  logic       w_accept;
  logic       w_start_bus;
  logic       w_done;

  assign w_opcode    = EX_INSTR[6:0];
  assign w_f3        = EX_INSTR[14:12];
  assign w_is_load   = (w_opcode == OPC_LOAD);
  assign w_is_store  = (w_opcode == OPC_STORE);
  assign w_is_mem    = w_is_load || w_is_store;
  assign w_is_mret   = (EX_INSTR == INSTR_MRET);
  assign w_illegal   = (w_is_load && (w_f3 == 3'b111)) || (w_is_store && w_f3[2]);
  assign w_misal     = is_misaligned(w_f3[1:0], EX_RD[2:0]);
  assign w_accept    = EX_VALID && MA_READY;
  assign w_start_bus = w_accept && w_is_mem && !w_illegal && !w_misal;
  assign w_done      = ((r_state == S_REQ) && DMEM_GNT && DMEM_RVALID) ||
                       ((r_state == S_WAIT) && DMEM_RVALID);

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_addr;
  logic            r_we;
  logic [7:0]      r_wstrb;
  logic [63:0]     r_wdata;

  logic            r_wb_valid;
  logic [XLEN-1:0] r_wb_pc;
  logic [31:0]     r_wb_instr;
  logic            r_wb_rf_we;
  logic [4:0]      r_wb_rd_addr;
  logic [XLEN-1:0] r_wb_rd;
  logic            r_wb_csr_we;
  logic [11:0]     r_wb_csr_addr;
  logic [XLEN-1:0] r_wb_csrd;
  logic            r_wb_exc;
  logic [3:0]      r_wb_exc_cause;

  // State register for the bus transaction sequencer.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: a grant with a same-cycle response skips WAIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_bus) w_state_nxt = S_REQ;
      S_REQ:   if (DMEM_GNT) w_state_nxt = DMEM_RVALID ? S_IDLE : S_WAIT;
      S_WAIT:  if (DMEM_RVALID) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs; bus controls are only asserted in REQ.
  always_comb begin
    MA_READY   = (r_state == S_IDLE);
    DMEM_REQ   = (r_state == S_REQ);
    DMEM_WE    = 1'b0;
    DMEM_WSTRB = 8'h00;
    if (r_state == S_REQ) begin
      DMEM_WE    = r_we;
      DMEM_WSTRB = r_wstrb;
    end
  end

  // Latch memory requests and build the registered writeback bundle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pc           <= '0;
      r_instr        <= '0;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_wstrb        <= '0;
      r_wdata        <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_pc        <= '0;
      r_wb_instr     <= '0;
      r_wb_rf_we     <= 1'b0;
      r_wb_rd_addr   <= '0;
      r_wb_rd        <= '0;
      r_wb_csr_we    <= 1'b0;
      r_wb_csr_addr  <= '0;
      r_wb_csrd      <= '0;
      r_wb_exc       <= 1'b0;
      r_wb_exc_cause <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_wb_rf_we  <= 1'b0;
      r_wb_csr_we <= 1'b0;
      r_wb_exc    <= 1'b0;
      if (w_accept && !w_start_bus) begin
        r_wb_valid   <= 1'b1;
        r_wb_pc      <= EX_PC;
        r_wb_instr   <= EX_INSTR;
        r_wb_rd_addr <= EX_INSTR[11:7];
        if (w_is_mem) begin
          r_wb_exc       <= 1'b1;
          r_wb_exc_cause <= w_illegal ? 4'd2 : (w_is_load ? 4'd4 : 4'd6);
          r_wb_rd        <= '0;
        end else begin
          r_wb_rd       <= EX_RD;
          r_wb_rf_we    <= EX_WE && (EX_INSTR[11:7] != 5'd0);
          r_wb_csr_we   <= w_is_mret || (EX_WE && (w_opcode == OPC_SYSTEM) && (w_f3 != 3'b000));
          r_wb_csr_addr <= w_is_mret ? 12'h300 : EX_INSTR[31:20];
          r_wb_csrd     <= EX_CSRD;
        end
      end
      if (w_start_bus) begin
        r_pc    <= EX_PC;
        r_instr <= EX_INSTR;
        r_addr  <= EX_RD;
        r_we    <= w_is_store;
        r_wstrb <= w_is_store ? store_strobe(w_f3[1:0], EX_RD[2:0]) : 8'h00;
        r_wdata <= EX_RS2 << {EX_RD[2:0], 3'b000};
      end
      if (w_done) begin
        r_wb_valid   <= 1'b1;
        r_wb_pc      <= r_pc;
        r_wb_instr   <= r_instr;
        r_wb_rd_addr <= r_instr[11:7];
        r_wb_rf_we   <= !r_we && (r_instr[11:7] != 5'd0);
        r_wb_rd      <= r_we ? '0 : load_extend(r_instr[14:12], DMEM_RDATA >> {r_addr[2:0], 3'b000});
      end
    end
  end

  assign DMEM_ADDR    = {r_addr[XLEN-1:3], 3'b000};
  assign DMEM_WDATA   = r_wdata;
  assign WB_VALID     = r_wb_valid;
  assign WB_PC        = r_wb_pc;
  assign WB_INSTR     = r_wb_instr;
  assign WB_RF_WE     = r_wb_rf_we;
  assign WB_RD_ADDR   = r_wb_rd_addr;
  assign WB_RD        = r_wb_rd;
  assign WB_CSR_WE    = r_wb_csr_we;
  assign WB_CSR_ADDR  = r_wb_csr_addr;
  assign WB_CSRD      = r_wb_csrd;
  assign WB_EXC       = r_wb_exc;
  assign WB_EXC_CAUSE = r_wb_exc_cause;

endmodule

// File: tb/tb_leve1_ma.sv
// Bench for the LEVE1 memory-access stage: directed vector table, a few
// hand-written multi-cycle sequences, and randomized instructions checked
// against an arithmetic reference model.
module tb_leve1_ma;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        EX_VALID;
  logic [63:0] EX_PC;
  logic [31:0] EX_INSTR;
  logic        EX_WE;
  logic [63:0] EX_RD;
  logic [63:0] EX_CSRD;
  logic [63:0] EX_RS2;
  logic        MA_READY;
  logic        DMEM_REQ;
  logic [63:0] DMEM_ADDR;
  logic        DMEM_WE;
  logic [7:0]  DMEM_WSTRB;
  logic [63:0] DMEM_WDATA;
  logic        DMEM_GNT;
  logic        DMEM_RVALID;
  logic [63:0] DMEM_RDATA;
  logic        WB_VALID;
  logic [63:0] WB_PC;
  logic [31:0] WB_INSTR;
  logic        WB_RF_WE;
  logic [4:0]  WB_RD_ADDR;
  logic [63:0] WB_RD;
  logic        WB_CSR_WE;
  logic [11:0] WB_CSR_ADDR;
  logic [63:0] WB_CSRD;
  logic        WB_EXC;
  logic [3:0]  WB_EXC_CAUSE;

  leve1_ma #(.XLEN(64)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_INSTR(EX_INSTR), .EX_WE(EX_WE),
    .EX_RD(EX_RD), .EX_CSRD(EX_CSRD), .EX_RS2(EX_RS2),
    .MA_READY(MA_READY),
    .DMEM_REQ(DMEM_REQ), .DMEM_ADDR(DMEM_ADDR), .DMEM_WE(DMEM_WE),
    .DMEM_WSTRB(DMEM_WSTRB), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_GNT(DMEM_GNT), .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
    .WB_VALID(WB_VALID), .WB_PC(WB_PC), .WB_INSTR(WB_INSTR), .WB_RF_WE(WB_RF_WE),
    .WB_RD_ADDR(WB_RD_ADDR), .WB_RD(WB_RD), .WB_CSR_WE(WB_CSR_WE),
    .WB_CSR_ADDR(WB_CSR_ADDR), .WB_CSRD(WB_CSRD), .WB_EXC(WB_EXC),
    .WB_EXC_CAUSE(WB_EXC_CAUSE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rd;
    logic [63:0] rs2;
    logic [63:0] csrd;
    logic        we;
    logic [63:0] rdata;
    int          gnt;
    int          rvd;
    logic        exp_req;
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_wbrd;
    logic        exp_rfwe;
    logic        exp_csrwe;
    logic [11:0] exp_csraddr;
    logic        exp_exc;
    logic [3:0]  exp_cause;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cur_id = 0;

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", cur_id, what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: derives every expected field from the instruction rules.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rdn;
    int          size;
    int          off;
    int          strb;
    logic [63:0] m;
    logic [63:0] mask;
    e = v;
    opc = v.instr[6:0];
    f3 = v.instr[14:12];
    rdn = v.instr[11:7];
    size = 1 << f3[1:0];
    off = int'(v.rd[2:0]);
    e.exp_req = 0; e.exp_we = 0; e.exp_addr = 0; e.exp_wstrb = 0; e.exp_wdata = 0;
    e.exp_wbrd = 0; e.exp_rfwe = 0; e.exp_csrwe = 0; e.exp_csraddr = 0;
    e.exp_exc = 0; e.exp_cause = 0;
    if (opc == 7'h03 || opc == 7'h23) begin
      if ((opc == 7'h03 && f3 == 3'd7) || (opc == 7'h23 && f3 >= 3'd4)) begin
        e.exp_exc = 1; e.exp_cause = 4'd2;
      end else if ((off % size) != 0) begin
        e.exp_exc = 1; e.exp_cause = (opc == 7'h03) ? 4'd4 : 4'd6;
      end else begin
        e.exp_req = 1;
        e.exp_addr = v.rd - 64'(off);
        if (opc == 7'h23) begin
          e.exp_we = 1;
          strb = ((1 << size) - 1) << off;
          e.exp_wstrb = strb[7:0];
          e.exp_wdata = v.rs2 << (8 * off);
        end else begin
          m = v.rdata >> (8 * off);
          if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            m = m & mask;
            if (!f3[2] && m[8*size-1]) m = m | ~mask;
          end
          e.exp_wbrd = m;
          e.exp_rfwe = (rdn != 0);
        end
      end
    end else begin
      e.exp_wbrd = v.rd;
      e.exp_rfwe = v.we && (rdn != 0);
      if (v.instr == 32'h30200073) begin
        e.exp_csrwe = 1; e.exp_csraddr = 12'h300;
      end else if (opc == 7'h73 && f3 != 3'd0 && v.we) begin
        e.exp_csrwe = 1; e.exp_csraddr = v.instr[31:20];
      end
    end
    return e;
  endfunction

  // Issue one instruction, act as the bus slave, and compare the retirement.
  task automatic run_vec(input vec_t v);
    int          phase;
    int          reqc;
    int          waitc;
    logic        got;
    logic        bus;
    logic        unstable;
    logic        busy_bad;
    logic [63:0] a0;
    logic        we0;
    logic [7:0]  s0;
    logic [63:0] d0;
    check("ready_before_issue", MA_READY, 1);
    EX_VALID = 1; EX_PC = v.pc; EX_INSTR = v.instr; EX_RD = v.rd;
    EX_RS2 = v.rs2; EX_CSRD = v.csrd; EX_WE = v.we;
    tick();
    EX_VALID = 0; EX_PC = {$urandom, $urandom}; EX_INSTR = $urandom;
    EX_RD = {$urandom, $urandom}; EX_RS2 = {$urandom, $urandom}; EX_WE = $urandom;
    phase = 0; reqc = 0; waitc = 0; got = 0; bus = 0; unstable = 0; busy_bad = 0;
    a0 = 0; we0 = 0; s0 = 0; d0 = 0;
    for (int c = 0; c < 40; c++) begin
      if (WB_VALID) begin
        got = 1;
        check("latency", 64'(c), v.exp_req ? 64'(v.gnt + v.rvd + 1) : 64'd0);
        check("ready_at_retire", MA_READY, 1);
        check("wb_pc", WB_PC, v.pc);
        check("wb_instr", 64'(WB_INSTR), 64'(v.instr));
        check("wb_rd_addr", 64'(WB_RD_ADDR), 64'(v.instr[11:7]));
        check("wb_rd", WB_RD, v.exp_wbrd);
        check("wb_rf_we", WB_RF_WE, v.exp_rfwe);
        check("wb_csr_we", WB_CSR_WE, v.exp_csrwe);
        if (v.exp_csrwe) begin
          check("wb_csr_addr", 64'(WB_CSR_ADDR), 64'(v.exp_csraddr));
          check("wb_csrd", WB_CSRD, v.csrd);
        end
        check("wb_exc", WB_EXC, v.exp_exc);
        if (v.exp_exc) check("wb_exc_cause", 64'(WB_EXC_CAUSE), 64'(v.exp_cause));
        break;
      end
      if (MA_READY) busy_bad = 1;
      if (DMEM_REQ) begin
        if (!bus) begin
          a0 = DMEM_ADDR; we0 = DMEM_WE; s0 = DMEM_WSTRB; d0 = DMEM_WDATA; bus = 1;
        end else if (DMEM_ADDR !== a0 || DMEM_WE !== we0 || DMEM_WSTRB !== s0 || DMEM_WDATA !== d0) begin
          unstable = 1;
        end
        if (reqc == v.gnt) begin
          DMEM_GNT = 1;
          if (v.rvd == 0) begin
            DMEM_RVALID = 1; DMEM_RDATA = v.rdata;
          end else begin
            phase = 1;
          end
        end else begin
          DMEM_RVALID = 1;
          DMEM_RDATA = ~v.rdata;
        end
        reqc++;
      end else if (phase == 1) begin
        waitc++;
        if (waitc == v.rvd) begin
          DMEM_RVALID = 1; DMEM_RDATA = v.rdata; phase = 2;
        end
      end
      tick();
      DMEM_GNT = 0; DMEM_RVALID = 0; DMEM_RDATA = {$urandom, $urandom};
    end
    check("retired_within_budget", got, 1);
    check("bus_requested", bus, v.exp_req);
    check("busy_while_outstanding", busy_bad, 0);
    if (v.exp_req) begin
      check("req_stable", unstable, 0);
      check("dmem_addr", a0, v.exp_addr);
      check("dmem_we", we0, v.exp_we);
      check("dmem_wstrb", 64'(s0), 64'(v.exp_wstrb));
      if (v.exp_we) check("dmem_wdata", d0, v.exp_wdata);
    end
    tick();
    check("single_pulse", WB_VALID, 0);
  endtask

  vec_t tbl[17];
  vec_t rv;
  int   kind;
  logic [2:0] rf3;

  initial begin
    RSTn = 0; EX_VALID = 0; EX_PC = 0; EX_INSTR = 0; EX_WE = 0; EX_RD = 0;
    EX_CSRD = 0; EX_RS2 = 0; DMEM_GNT = 0; DMEM_RVALID = 0; DMEM_RDATA = 0;

    // instr, pc, rd, rs2, csrd, we, rdata, gnt, rvd | req, we, addr, wstrb, wdata, wbrd, rfwe, csrwe, csraddr, exc, cause
    tbl[0]  = '{32'h00000293, 64'h100, 64'h1234, 64'h0, 64'h0, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h1234, 1'b1, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[1]  = '{32'h00000013, 64'h104, 64'h55, 64'h0, 64'h0, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h55, 1'b0, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[2]  = '{32'h00000303, 64'h108, 64'h1003, 64'h0, 64'h0, 1'b1, 64'h00000000_80000000, 2, 3,
                1'b1, 1'b0, 64'h1000, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80, 1'b1, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[3]  = '{32'h00004303, 64'h10C, 64'h1003, 64'h0, 64'h0, 1'b1, 64'h00000000_80000000, 2, 3,
                1'b1, 1'b0, 64'h1000, 8'h00, 64'h0, 64'h80, 1'b1, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[4]  = '{32'h00002023, 64'h110, 64'h2004, 64'hDEADBEEF, 64'h0, 1'b1, 64'h0, 0, 1,
                1'b1, 1'b1, 64'h2000, 8'hF0, 64'hDEADBEEF_00000000, 64'h0, 1'b0, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[5]  = '{32'h00003383, 64'h114, 64'h3004, 64'h0, 64'h0, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0, 12'h0, 1'b1, 4'd4};
    tbl[6]  = '{32'h00001023, 64'h118, 64'h11, 64'h0, 64'h0, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0, 12'h0, 1'b1, 4'd6};
    tbl[7]  = '{32'h00002403, 64'h11C, 64'h8, 64'h0, 64'h0, 1'b1, 64'h12345678_9ABCDEF0, 1, 0,
                1'b1, 1'b0, 64'h8, 8'h00, 64'h0, 64'hFFFFFFFF_9ABCDEF0, 1'b1, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[8]  = '{32'h00002403, 64'h120, 64'hC, 64'h0, 64'h0, 1'b1, 64'h80000001_00000000, 0, 0,
                1'b1, 1'b0, 64'h8, 8'h00, 64'h0, 64'hFFFFFFFF_80000001, 1'b1, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[9]  = '{32'h341014F3, 64'h124, 64'hAA, 64'h0, 64'h8000_0000, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'hAA, 1'b1, 1'b1, 12'h341, 1'b0, 4'd0};
    tbl[10] = '{32'h30200073, 64'h128, 64'h0, 64'h0, 64'h1880, 1'b0, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1, 12'h300, 1'b0, 4'd0};
    tbl[11] = '{32'h00007303, 64'h12C, 64'h2000, 64'h0, 64'h0, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0, 12'h0, 1'b1, 4'd2};
    tbl[12] = '{32'h00004023, 64'h130, 64'h2000, 64'h0, 64'h0, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0, 12'h0, 1'b1, 4'd2};
    tbl[13] = '{32'h00000073, 64'h134, 64'h77, 64'h0, 64'h0, 1'b1, 64'h0, 0, 0,
                1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h77, 1'b0, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[14] = '{32'h00003023, 64'h138, 64'h4000, 64'h01234567_89ABCDEF, 64'h0, 1'b1, 64'h0, 3, 2,
                1'b1, 1'b1, 64'h4000, 8'hFF, 64'h01234567_89ABCDEF, 64'h0, 1'b0, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[15] = '{32'h00005303, 64'h13C, 64'h100E, 64'h0, 64'h0, 1'b1, 64'hBEEF0000_00000000, 1, 1,
                1'b1, 1'b0, 64'h1008, 8'h00, 64'h0, 64'hBEEF, 1'b1, 1'b0, 12'h0, 1'b0, 4'd0};
    tbl[16] = '{32'h00001303, 64'h140, 64'h100E, 64'h0, 64'h0, 1'b1, 64'hBEEF0000_00000000, 1, 1,
                1'b1, 1'b0, 64'h1008, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFBEEF, 1'b1, 1'b0, 12'h0, 1'b0, 4'd0};

    // Reset state
    tick();
    tick();
    check("rst_ma_ready", MA_READY, 1);
    check("rst_dmem_req", DMEM_REQ, 0);
    check("rst_dmem_we", DMEM_WE, 0);
    check("rst_dmem_wstrb", 64'(DMEM_WSTRB), 0);
    check("rst_dmem_addr", DMEM_ADDR, 0);
    check("rst_wb_valid", WB_VALID, 0);
    check("rst_wb_rf_we", WB_RF_WE, 0);
    check("rst_wb_csr_we", WB_CSR_WE, 0);
    check("rst_wb_exc", WB_EXC, 0);
    check("rst_wb_rd", WB_RD, 0);
    RSTn = 1;
    tick();

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      cur_id = i;
      run_vec(tbl[i]);
    end

    // Back-to-back non-memory instructions retire every cycle
    cur_id = 100;
    EX_WE = 1; EX_CSRD = 0; EX_RS2 = 0;
    for (int i = 1; i <= 3; i++) begin
      EX_VALID = 1;
      EX_INSTR = {12'h0, 5'd0, 3'b000, 5'(i), 7'b0010011};
      EX_PC = 64'h200 + 64'(4 * i);
      EX_RD = 64'h1000 + 64'(i);
      tick();
      check("b2b_wb_valid", WB_VALID, 1);
      check("b2b_wb_rd", WB_RD, 64'h1000 + 64'(i));
      check("b2b_wb_rd_addr", 64'(WB_RD_ADDR), 64'(i));
      check("b2b_ready", MA_READY, 1);
    end
    EX_VALID = 0;
    tick();
    check("b2b_end_pulse", WB_VALID, 0);

    // Reset while waiting for the response drops the load
    cur_id = 101;
    EX_VALID = 1; EX_INSTR = 32'h00002403; EX_PC = 64'h300; EX_RD = 64'h8; EX_WE = 1;
    tick();
    EX_VALID = 0;
    check("rw_req", DMEM_REQ, 1);
    DMEM_GNT = 1;
    tick();
    DMEM_GNT = 0;
    check("rw_wait_busy", MA_READY, 0);
    check("rw_wait_noreq", DMEM_REQ, 0);
    RSTn = 0;
    #1;
    check("rw_rst_ready", MA_READY, 1);
    check("rw_rst_noreq", DMEM_REQ, 0);
    check("rw_rst_wb_valid", WB_VALID, 0);
    @(negedge CLK);
    RSTn = 1;
    tick();
    DMEM_RVALID = 1; DMEM_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    DMEM_RVALID = 0;
    for (int i = 0; i < 3; i++) begin
      check("rw_no_retire", WB_VALID, 0);
      check("rw_idle_ready", MA_READY, 1);
      tick();
    end

    // Randomized instructions against the reference model
    for (int i = 0; i < 150; i++) begin
      cur_id = 1000 + i;
      kind = int'($urandom_range(0, 3));
      rf3 = 3'($urandom_range(0, 7));
      rv = tbl[0];
      rv.pc = {$urandom, $urandom};
      rv.rd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rv.rd[2:0] = 3'b000;
      rv.rs2 = {$urandom, $urandom};
      rv.csrd = {$urandom, $urandom};
      rv.we = 1'($urandom_range(0, 1));
      rv.rdata = {$urandom, $urandom};
      rv.gnt = int'($urandom_range(0, 3));
      rv.rvd = int'($urandom_range(0, 3));
      case (kind)
        0:       rv.instr = {12'($urandom), 5'($urandom), rf3, 5'($urandom), 7'b0000011};
        1:       rv.instr = {12'($urandom), 5'($urandom), rf3, 5'($urandom), 7'b0100011};
        2:       rv.instr = {12'($urandom), 5'($urandom), rf3, 5'($urandom), 7'b0010011};
        default: rv.instr = {12'($urandom), 5'($urandom), rf3, 5'($urandom), 7'b1110011};
      endcase
      if (kind == 3 && $urandom_range(0, 7) == 0) rv.instr = 32'h30200073;
      run_vec(model(rv));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
